// File: rtl/fcta_cfg_stream_tx.sv
// Transmit side of the 96-bit configuration AXI-Stream: packs 32-bit control
// words into beats, buffers whole beats in a small FIFO and streams them out.
module fcta_cfg_stream_tx #(
  parameter int CFG_REG_BW     = 32,
  parameter int CFG_BW         = 96,
  parameter int WORDS_PER_BEAT = CFG_BW / CFG_REG_BW,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_BW         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [CFG_REG_BW-1:0]         wr_data,
  input  logic                          wr_last,
  output logic                          wr_ready,
  output logic                          m_axis_cfg_tvalid,
  output logic                          m_axis_cfg_tlast,
  output logic [CFG_BW-1:0]             m_axis_cfg_tdata,
  input  logic                          m_axis_cfg_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_BW-1:0]             beats_sent,
  output logic [CNT_BW-1:0]             pkts_sent,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int KW = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
  localparam logic [KW-1:0] K_LAST  = KW'(WORDS_PER_BEAT - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [KW-1:0]     k;
  logic [CFG_BW-1:0] staging;
  logic [CFG_BW-1:0] beat;
  logic [CFG_BW-1:0] mem_data [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              accept;
  logic              push;
  logic              pop;

  // Readiness looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign wr_ready = !rst && (fifo_count < DEPTH_C);
  assign accept   = wr_valid && wr_ready;
  assign push     = accept && ((k == K_LAST) || wr_last);

  assign m_axis_cfg_tvalid = (fifo_count != '0);
  assign pop               = m_axis_cfg_tvalid && m_axis_cfg_tready;
  assign m_axis_cfg_tdata  = m_axis_cfg_tvalid ? mem_data[rd_ptr] : '0;
  assign m_axis_cfg_tlast  = m_axis_cfg_tvalid && mem_last[rd_ptr];
  assign busy              = (k != '0) || (fifo_count != '0);

  always_comb begin
    beat = staging;
    beat[int'(k) * CFG_REG_BW +: CFG_REG_BW] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k       <= '0;
      staging <= '0;
    end else if (accept) begin
      if (push) begin
        k       <= '0;
        staging <= '0;
      end else begin
        k       <= k + 1'b1;
        staging <= beat;
      end
    end
  end

  // Storage needs no reset: the head is only visible while fifo_count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= beat;
      mem_last[wr_ptr] <= wr_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_sent <= '0;
      pkts_sent  <= '0;
    end else if (pop) begin
      beats_sent <= beats_sent + 1'b1;
      if (m_axis_cfg_tlast) pkts_sent <= pkts_sent + 1'b1;
    end
  end

endmodule

// File: tb/tb_fcta_cfg_stream_tx.sv
// Directed bench for fcta_cfg_stream_tx; statistics counters are narrowed to
// 8 bits so their wrap is reached in a few hundred packets.
module tb_fcta_cfg_stream_tx;

  localparam int CNT_BW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_last = 1'b0;
  logic        wr_ready;
  logic        m_axis_cfg_tvalid;
  logic        m_axis_cfg_tlast;
  logic [95:0] m_axis_cfg_tdata;
  logic        m_axis_cfg_tready = 1'b1;
  logic [2:0]  fifo_count;
  logic [CNT_BW-1:0] beats_sent;
  logic [CNT_BW-1:0] pkts_sent;
  logic        busy;

  int passes = 0;
  int total  = 0;

  fcta_cfg_stream_tx #(
    .CFG_REG_BW(32), .CFG_BW(96), .FIFO_DEPTH(4), .CNT_BW(CNT_BW)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .m_axis_cfg_tvalid(m_axis_cfg_tvalid), .m_axis_cfg_tlast(m_axis_cfg_tlast),
    .m_axis_cfg_tdata(m_axis_cfg_tdata), .m_axis_cfg_tready(m_axis_cfg_tready),
    .fifo_count(fifo_count), .beats_sent(beats_sent), .pkts_sent(pkts_sent), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [95:0] pack3(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [31:0] bp_word(input int i);
    return 32'hB000_0000 + 32'(i);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Offers one word and returns on the falling edge after its handshake.
  task automatic applyStimulus(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = l;
    while (!wr_ready && n < 50) begin
      step();
      n++;
    end
    checkOutput("wr_ready_wait", 128'(wr_ready), 128'(1));
    step();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    checkOutput("rst_wr_ready", 128'(wr_ready), 128'(0));
    checkOutput("rst_tvalid", 128'(m_axis_cfg_tvalid), 128'(0));
    checkOutput("rst_tdata", 128'(m_axis_cfg_tdata), 128'(0));
    checkOutput("rst_count", 128'(fifo_count), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_beats", 128'(beats_sent), 128'(0));
    rst = 1'b0;
    step();
    checkOutput("rel_wr_ready", 128'(wr_ready), 128'(1));

    // Basic beat
    m_axis_cfg_tready = 1'b1;
    applyStimulus(32'h1111_1111, 1'b0);
    applyStimulus(32'h2222_2222, 1'b0);
    checkOutput("basic_busy_partial", 128'(busy), 128'(1));
    checkOutput("basic_tvalid_early", 128'(m_axis_cfg_tvalid), 128'(0));
    applyStimulus(32'h3333_3333, 1'b1);
    checkOutput("basic_tvalid", 128'(m_axis_cfg_tvalid), 128'(1));
    checkOutput("basic_tdata", 128'(m_axis_cfg_tdata), 128'(96'h3333_3333_2222_2222_1111_1111));
    checkOutput("basic_tlast", 128'(m_axis_cfg_tlast), 128'(1));
    step();
    checkOutput("basic_tvalid_after", 128'(m_axis_cfg_tvalid), 128'(0));
    checkOutput("basic_beats", 128'(beats_sent), 128'(1));
    checkOutput("basic_pkts", 128'(pkts_sent), 128'(1));
    checkOutput("basic_busy", 128'(busy), 128'(0));

    // Early last, then a full packet from index 0
    applyStimulus(32'hAAAA_0001, 1'b1);
    checkOutput("early_tdata", 128'(m_axis_cfg_tdata), 128'(96'h0000_0000_0000_0000_AAAA_0001));
    checkOutput("early_tlast", 128'(m_axis_cfg_tlast), 128'(1));
    applyStimulus(32'h1, 1'b0);
    applyStimulus(32'h2, 1'b0);
    applyStimulus(32'h3, 1'b1);
    checkOutput("next_tdata", 128'(m_axis_cfg_tdata), 128'(96'h0000_0003_0000_0002_0000_0001));
    step();
    checkOutput("next_beats", 128'(beats_sent), 128'(3));
    checkOutput("next_pkts", 128'(pkts_sent), 128'(3));

    // Backpressure fill: four beats fill the FIFO, word 13 stalls
    m_axis_cfg_tready = 1'b0;
    for (int i = 1; i <= 12; i++) applyStimulus(bp_word(i), 1'b0);
    checkOutput("bp_count_full", 128'(fifo_count), 128'(4));
    checkOutput("bp_wr_ready_low", 128'(wr_ready), 128'(0));
    checkOutput("bp_head", 128'(m_axis_cfg_tdata), 128'(pack3(bp_word(1), bp_word(2), bp_word(3))));
    checkOutput("bp_head_tlast", 128'(m_axis_cfg_tlast), 128'(0));
    wr_valid = 1'b1;
    wr_data  = bp_word(13);
    wr_last  = 1'b0;
    step();
    step();
    checkOutput("bp_stall_count", 128'(fifo_count), 128'(4));
    checkOutput("bp_stall_busy", 128'(busy), 128'(1));
    checkOutput("bp_stall_head", 128'(m_axis_cfg_tdata), 128'(pack3(bp_word(1), bp_word(2), bp_word(3))));
    m_axis_cfg_tready = 1'b1;
    step();
    m_axis_cfg_tready = 1'b0;
    checkOutput("bp_after_pop_count", 128'(fifo_count), 128'(3));
    checkOutput("bp_after_pop_ready", 128'(wr_ready), 128'(1));
    checkOutput("bp_beat1", 128'(m_axis_cfg_tdata), 128'(pack3(bp_word(4), bp_word(5), bp_word(6))));
    step();
    wr_valid = 1'b0;
    applyStimulus(bp_word(14), 1'b0);
    applyStimulus(bp_word(15), 1'b1);
    checkOutput("bp_refill_count", 128'(fifo_count), 128'(4));
    m_axis_cfg_tready = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      checkOutput("bp_drain_tvalid", 128'(m_axis_cfg_tvalid), 128'(1));
      checkOutput("bp_drain_tdata", 128'(m_axis_cfg_tdata),
                  128'(pack3(bp_word(3*b+1), bp_word(3*b+2), bp_word(3*b+3))));
      checkOutput("bp_drain_tlast", 128'(m_axis_cfg_tlast), 128'(b == 4));
      step();
    end
    checkOutput("bp_empty", 128'(m_axis_cfg_tvalid), 128'(0));
    checkOutput("bp_beats", 128'(beats_sent), 128'(8));
    checkOutput("bp_pkts", 128'(pkts_sent), 128'(4));

    // Throughput: continuous words, one beat every three cycles
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(32'hC000_0000 + 32'(i), i == 9);
      if (i % 3 == 0) begin
        checkOutput("tp_tvalid", 128'(m_axis_cfg_tvalid), 128'(1));
        checkOutput("tp_tdata", 128'(m_axis_cfg_tdata),
                    128'(pack3(32'hC000_0000 + 32'(i-2), 32'hC000_0000 + 32'(i-1),
                               32'hC000_0000 + 32'(i))));
        checkOutput("tp_tlast", 128'(m_axis_cfg_tlast), 128'(i == 9));
      end else begin
        checkOutput("tp_tvalid_idle", 128'(m_axis_cfg_tvalid), 128'(0));
      end
    end
    step();
    checkOutput("tp_beats", 128'(beats_sent), 128'(11));
    checkOutput("tp_pkts", 128'(pkts_sent), 128'(5));

    // Toggling tready: data holds while stalled
    m_axis_cfg_tready = 1'b0;
    for (int i = 1; i <= 6; i++) applyStimulus(32'hD000_0000 + 32'(i), i == 6);
    step();
    checkOutput("tog_hold_a", 128'(m_axis_cfg_tdata), 128'(96'hD000_0003_D000_0002_D000_0001));
    checkOutput("tog_hold_a_last", 128'(m_axis_cfg_tlast), 128'(0));
    m_axis_cfg_tready = 1'b1;
    step();
    m_axis_cfg_tready = 1'b0;
    checkOutput("tog_b", 128'(m_axis_cfg_tdata), 128'(96'hD000_0006_D000_0005_D000_0004));
    step();
    checkOutput("tog_hold_b", 128'(m_axis_cfg_tdata), 128'(96'hD000_0006_D000_0005_D000_0004));
    checkOutput("tog_hold_b_last", 128'(m_axis_cfg_tlast), 128'(1));
    m_axis_cfg_tready = 1'b1;
    step();
    m_axis_cfg_tready = 1'b0;
    checkOutput("tog_empty", 128'(m_axis_cfg_tvalid), 128'(0));
    checkOutput("tog_beats", 128'(beats_sent), 128'(13));
    checkOutput("tog_pkts", 128'(pkts_sent), 128'(6));

    // Reset with two buffered beats and two staged words
    for (int i = 1; i <= 8; i++) applyStimulus(32'hE000_0000 + 32'(i), 1'b0);
    checkOutput("mid_count", 128'(fifo_count), 128'(2));
    checkOutput("mid_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_tvalid", 128'(m_axis_cfg_tvalid), 128'(0));
    checkOutput("mid_rst_count", 128'(fifo_count), 128'(0));
    checkOutput("mid_rst_beats", 128'(beats_sent), 128'(0));
    checkOutput("mid_rst_pkts", 128'(pkts_sent), 128'(0));
    checkOutput("mid_rst_tdata", 128'(m_axis_cfg_tdata), 128'(0));
    checkOutput("mid_rst_busy", 128'(busy), 128'(0));
    checkOutput("mid_rst_wr_ready", 128'(wr_ready), 128'(0));
    step();
    rst = 1'b0;
    m_axis_cfg_tready = 1'b1;
    step();
    applyStimulus(32'hF000_0001, 1'b0);
    applyStimulus(32'hF000_0002, 1'b0);
    applyStimulus(32'hF000_0003, 1'b1);
    checkOutput("fresh_tdata", 128'(m_axis_cfg_tdata), 128'(96'hF000_0003_F000_0002_F000_0001));
    checkOutput("fresh_tlast", 128'(m_axis_cfg_tlast), 128'(1));
    step();
    checkOutput("fresh_beats", 128'(beats_sent), 128'(1));
    checkOutput("fresh_pkts", 128'(pkts_sent), 128'(1));
    checkOutput("fresh_empty", 128'(fifo_count), 128'(0));

    // Counter wrap with single-word packets
    for (int n = 1; n <= 255; n++) begin
      applyStimulus(32'(n), 1'b1);
      if (n % 64 == 0) begin
        checkOutput("wrap_pkts", 128'(pkts_sent), 128'(n % 256));
        checkOutput("wrap_beats", 128'(beats_sent), 128'(n % 256));
      end
    end
    checkOutput("wrap_tdata", 128'(m_axis_cfg_tdata), 128'(96'h0000_00FF));
    step();
    checkOutput("wrap_pkts_zero", 128'(pkts_sent), 128'(0));
    checkOutput("wrap_beats_zero", 128'(beats_sent), 128'(0));
    checkOutput("wrap_idle", 128'(m_axis_cfg_tvalid), 128'(0));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/fcta_cfg_stream_tx.md
Name: fcta_cfg_stream_tx

Overview:
- Transmit side of the accelerator's 96-bit configuration AXI-Stream.
- Accepts 32-bit configuration register words from the control plane (GPIO-style write strobe).
- Packs every three words into one CFG_BW beat and buffers complete beats in a small FIFO.
- Drives beats into the accelerator's s_axis_cfg port with full valid/ready/last handshaking.

Parameters:
- CFG_REG_BW, 32, width of one control-plane word.
- CFG_BW, 96, width of one config stream beat; must be an integer multiple of CFG_REG_BW.
- WORDS_PER_BEAT, CFG_BW/CFG_REG_BW (3), words packed per beat.
- FIFO_DEPTH, 4, number of complete beats buffered; power of two, at least 2.
- CNT_BW, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  control word present.
- wr_data  in  CFG_REG_BW  control word.
- wr_last  in  1  this word ends the configuration packet.
- wr_ready  out  1  word accepted when wr_valid and wr_ready are both high.
- m_axis_cfg_tvalid  out  1  beat valid.
- m_axis_cfg_tlast  out  1  last beat of the packet.
- m_axis_cfg_tdata  out  CFG_BW  beat payload.
- m_axis_cfg_tready  in  1  downstream ready.
- fifo_count  out  clog2(FIFO_DEPTH)+1  beats currently buffered.
- beats_sent  out  CNT_BW  count of completed output handshakes; wraps.
- pkts_sent  out  CNT_BW  count of handshakes with tlast=1; wraps.
- busy  out  1  high when the packer is partially filled or fifo_count is nonzero.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Packer index, staging register, FIFO pointers, fifo_count and both counters clear to 0.
  - m_axis_cfg_tvalid, m_axis_cfg_tlast and busy go to 0; m_axis_cfg_tdata goes to 0.
  - wr_ready goes to 0 while rst is high and is 1 from the first cycle after release.
  - Reset mid-packet discards partial words and buffered beats. Nothing is resumed.
- Packing:
  - Word index k counts 0..WORDS_PER_BEAT-1.
  - An accepted word is written to staging bits [k*CFG_REG_BW +: CFG_REG_BW]. The first word goes to the LSBs.
  - A beat completes when k = WORDS_PER_BEAT-1, or when wr_last=1 at any k.
  - On completion, the staging contents plus the accepted word are pushed into the FIFO with last=wr_last. Unfilled upper words are zero-padded. k then returns to 0 and staging clears.
  - On a non-completing word, k increments.
- Input flow control:
  - wr_ready = !rst_active && (fifo_count < FIFO_DEPTH).
  - The readiness check is registered state only. A pop in the same cycle does not free space for a push.
  - Non-completing words are also blocked while the FIFO is full. This keeps the decision to a single term.
- FIFO:
  - Circular buffer; read and write pointers wrap at FIFO_DEPTH.
  - fifo_count changes as follows:
    - +1 on a push alone.
    - -1 on a pop alone.
    - Unchanged on a simultaneous push and pop (legal when 0 < count < DEPTH).
  - Push into an empty FIFO: m_axis_cfg_tvalid rises on the next cycle. Latency from the completing word handshake to tvalid is 1 cycle.
- Output (AXI-Stream master):
  - tvalid = (fifo_count != 0). tdata and tlast reflect the FIFO head.
  - Once tvalid is high, tvalid, tdata and tlast stay stable until a handshake (tvalid && tready).
  - tvalid never depends combinationally on tready.
  - A handshake pops the head. The next beat is presented on the following cycle, so back-to-back beats sustain 1 beat per cycle.
  - beats_sent increments per handshake. pkts_sent increments per handshake with tlast=1. Both wrap at 2^CNT_BW.
- Errors: none are flagged. Words offered while wr_ready=0 are simply not accepted.

Test Plan:
- Basic beat: write 0x11111111, 0x22222222, 0x33333333 (wr_last on the third) with tready=1.
  - tvalid rises 1 cycle after the third handshake.
  - tdata = 0x333333332222222211111111, tlast=1.
  - beats_sent=1, pkts_sent=1, busy=0 afterwards.
- Early last: write 0xAAAA0001 with wr_last=1.
  - tdata = 0x0000000000000000AAAA0001, tlast=1.
  - The next packet starts at word index 0.
- Backpressure fill: hold tready=0 and write 15 words (5 beats, last on word 15).
  - wr_ready drops after beat 4 completes; fifo_count=4.
  - Word 13 stalls until tready=1.
  - All 5 beats then emerge in order with stable data.
  - tlast is set only on beat 5.
- Throughput: keep tready=1 and feed words continuously.
  - 1 beat per 3 cycles out, no drops, beats_sent tracks exactly.
  - Toggling tready every cycle never changes tdata while tvalid=1 and tready=0.
- Reset mid-operation: assert rst with 2 words in the packer and 2 beats buffered.
  - tvalid, fifo_count and counters go to 0 immediately.
  - After release, a fresh 3-word packet produces one correct beat with no stale data.
- Counter wrap: preload via 65536 single-word packets with CNT_BW=16.
  - pkts_sent wraps to 0.
  - beats_sent equals pkts_sent throughout.
